// File: rtl/rx_event_scheduler.sv
// rx_event_scheduler
//   Buffers completed-message events from the receive processor in a small
//   FIFO and arbitrates them round-robin against timer expiries and host
//   commands onto one valid/ready event port into the session manager. It also
//   keeps the expected incoming sequence number used by the processor.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rx_new_message_i    pulse: message complete; rx_error_type_i / rx_type_i sampled with it
//   tmr_expire_i        pulse: timer expired; tmr_id_i sampled with it
//   host_req_i          level request held until host_ack_o; host_cmd_i stable meanwhile
//   host_ack_o          pulse in the cycle the host command is captured
//   evt_valid_o/evt_ready_i, evt_src_o, evt_code_o
//                       event port (src 0=rx {type,err}, 1=timer {6'b0,id}, 2=host {4'b0,cmd})
//   seq_load_i, seq_load_val_i, expected_seq_o
//                       expected incoming sequence number (load has priority)
//   overflow_o, drop_count_o
//                       sticky rx drop flag, saturating drop counter
//
// Message type codes that do not advance the sequence number:
//   4'h4 = SequenceReset, 4'h5 = GapFill (4'h1 = Logon, for reference).
module rx_event_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int COUNTER_DEPTH = 80
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_new_message_i,
    input  logic [3:0]               rx_error_type_i,
    input  logic [3:0]               rx_type_i,
    input  logic                     tmr_expire_i,
    input  logic [1:0]               tmr_id_i,
    input  logic                     host_req_i,
    input  logic [3:0]               host_cmd_i,
    output logic                     host_ack_o,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [1:0]               evt_src_o,
    output logic [7:0]               evt_code_o,
    input  logic                     seq_load_i,
    input  logic [COUNTER_DEPTH-1:0] seq_load_val_i,
    output logic [COUNTER_DEPTH-1:0] expected_seq_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_count_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] SRC_RX   = 2'd0;
    localparam logic [1:0] SRC_TMR  = 2'd1;
    localparam logic [1:0] SRC_HOST = 2'd2;

    localparam logic [3:0] TYPE_SEQ_RESET = 4'h4;
    localparam logic [3:0] TYPE_GAP_FILL  = 4'h5;

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               ptr_q, ptr_d;
    logic                     valid_q, valid_d;
    logic [1:0]               src_q, src_d;
    logic [7:0]               code_q, code_d;
    logic                     tmr_pend_q, tmr_pend_d;
    logic [1:0]               tmr_id_q, tmr_id_d;
    logic                     host_pend_q, host_pend_d;
    logic [3:0]               host_cmd_q, host_cmd_d;
    logic                     ack_prev_q, ack_prev_d;
    logic [COUNTER_DEPTH-1:0] seq_q, seq_d;
    logic                     ovf_q, ovf_d;
    logic [7:0]               drop_q, drop_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               fifo_mem_q [FIFO_DEPTH];

    logic       host_ack;
    logic       rx_pend;
    logic       grant;
    logic [1:0] win;
    logic [1:0] cand;
    logic       pop;
    logic       push_ok;
    logic       fifo_full;

    // rx -> timer -> host -> rx
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_HOST) ? SRC_RX : s + 2'd1;
    endfunction

    function automatic logic src_pending(input logic [1:0] s, input logic rx_p,
                                         input logic tmr_p, input logic host_p);
        case (s)
            SRC_RX:   return rx_p;
            SRC_TMR:  return tmr_p;
            SRC_HOST: return host_p;
            default:  return 1'b0;
        endcase
    endfunction

    // Only clean, ordinary messages consume a sequence number.
    function automatic logic seq_qualifies(input logic [7:0] code);
        return (code[3:0] == 4'h0) && (code[7:4] != TYPE_SEQ_RESET) &&
               (code[7:4] != TYPE_GAP_FILL);
    endfunction

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        valid_d     = valid_q;
        src_d       = src_q;
        code_d      = code_q;
        tmr_pend_d  = tmr_pend_q;
        tmr_id_d    = tmr_id_q;
        host_pend_d = host_pend_q;
        host_cmd_d  = host_cmd_q;
        seq_d       = seq_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        grant       = 1'b0;
        win         = ptr_q;
        cand        = ptr_q;

        // ack_prev_q stops a still-high request from being taken twice in a row.
        host_ack   = host_req_i && !host_pend_q && !ack_prev_q && !rst;
        ack_prev_d = host_ack;
        rx_pend    = (cnt_q != '0);

        for (int k = 0; k < 3; k++) begin
            if (!grant && src_pending(cand, rx_pend, tmr_pend_q, host_pend_q)) begin
                grant = 1'b1;
                win   = cand;
            end
            cand = next_src(cand);
        end

        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    valid_d = 1'b1;
                    src_d   = win;
                    ptr_d   = next_src(win);
                    state_d = S_PRESENT;
                    case (win)
                        SRC_RX: begin
                            code_d = fifo_mem_q[rd_ptr_q];
                            pop    = 1'b1;
                        end
                        SRC_TMR: begin
                            code_d     = {6'b0, tmr_id_q};
                            tmr_pend_d = 1'b0;
                        end
                        default: begin
                            code_d      = {4'b0, host_cmd_q};
                            host_pend_d = 1'b0;
                        end
                    endcase
                end
            end
            default: begin
                if (evt_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase

        // A fresh expiry overrides a same-cycle grant clear; repeated expiries merge.
        if (tmr_expire_i) begin
            tmr_pend_d = 1'b1;
            tmr_id_d   = tmr_id_i;
        end
        if (host_ack) begin
            host_pend_d = 1'b1;
            host_cmd_d  = host_cmd_i;
        end

        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        fifo_full = (cnt_q == CW'(FIFO_DEPTH));
        push_ok   = rx_new_message_i && (!fifo_full || pop);
        if (rx_new_message_i && !push_ok) begin
            ovf_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        if (seq_load_i) begin
            seq_d = seq_load_val_i;
        end else if (state_q == S_PRESENT && evt_ready_i && src_q == SRC_RX &&
                     seq_qualifies(code_q)) begin
            seq_d = seq_q + COUNTER_DEPTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= SRC_RX;
            valid_q     <= 1'b0;
            src_q       <= 2'd0;
            code_q      <= 8'd0;
            tmr_pend_q  <= 1'b0;
            tmr_id_q    <= 2'd0;
            host_pend_q <= 1'b0;
            host_cmd_q  <= 4'd0;
            ack_prev_q  <= 1'b0;
            seq_q       <= COUNTER_DEPTH'(1);
            ovf_q       <= 1'b0;
            drop_q      <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            src_q       <= src_d;
            code_q      <= code_d;
            tmr_pend_q  <= tmr_pend_d;
            tmr_id_q    <= tmr_id_d;
            host_pend_q <= host_pend_d;
            host_cmd_q  <= host_cmd_d;
            ack_prev_q  <= ack_prev_d;
            seq_q       <= seq_d;
            ovf_q       <= ovf_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= {rx_type_i, rx_error_type_i};
        end
    end

    assign host_ack_o     = host_ack;
    assign evt_valid_o    = valid_q;
    assign evt_src_o      = src_q;
    assign evt_code_o     = code_q;
    assign expected_seq_o = seq_q;
    assign overflow_o     = ovf_q;
    assign drop_count_o   = drop_q;

endmodule

// File: tb/tb_rx_event_scheduler.sv
module tb_rx_event_scheduler;

    localparam int CD = 80;
    localparam logic [3:0] TYPE_LOGON     = 4'h1;
    localparam logic [3:0] TYPE_SEQ_RESET = 4'h4;
    localparam logic [3:0] TYPE_GAP_FILL  = 4'h5;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_new_message_i;
    logic [3:0]    rx_error_type_i;
    logic [3:0]    rx_type_i;
    logic          tmr_expire_i;
    logic [1:0]    tmr_id_i;
    logic          host_req_i;
    logic [3:0]    host_cmd_i;
    logic          host_ack_o;
    logic          evt_valid_o;
    logic          evt_ready_i;
    logic [1:0]    evt_src_o;
    logic [7:0]    evt_code_o;
    logic          seq_load_i;
    logic [CD-1:0] seq_load_val_i;
    logic [CD-1:0] expected_seq_o;
    logic          overflow_o;
    logic [7:0]    drop_count_o;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         sb_en = 1'b1;
    logic [9:0] exp_q [$];
    logic [1:0] acc_src [$];
    int         acc_cyc [$];

    rx_event_scheduler #(.FIFO_DEPTH(4), .COUNTER_DEPTH(CD)) dut (
        .clk(clk), .rst(rst),
        .rx_new_message_i(rx_new_message_i), .rx_error_type_i(rx_error_type_i),
        .rx_type_i(rx_type_i), .tmr_expire_i(tmr_expire_i), .tmr_id_i(tmr_id_i),
        .host_req_i(host_req_i), .host_cmd_i(host_cmd_i), .host_ack_o(host_ack_o),
        .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i), .evt_src_o(evt_src_o),
        .evt_code_o(evt_code_o), .seq_load_i(seq_load_i), .seq_load_val_i(seq_load_val_i),
        .expected_seq_o(expected_seq_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted event is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && evt_valid_o && evt_ready_i) begin
            acc_src.push_back(evt_src_o);
            acc_cyc.push_back(cyc);
            if (sb_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got src=%0d code=%h, required no event", evt_src_o, evt_code_o);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({evt_src_o, evt_code_o} !== e) begin
                        errors++;
                        $display("FAIL sb_event got src=%0d code=%h, required src=%0d code=%h",
                                 evt_src_o, evt_code_o, e[9:8], e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, output bit ok);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", evt_valid_o); end
        checks++; if (evt_src_o !== 2'd0) begin errors++; $display("FAIL rst_src got %0d required 0", evt_src_o); end
        checks++; if (evt_code_o !== 8'h00) begin errors++; $display("FAIL rst_code got %h required 00", evt_code_o); end
        checks++; if (host_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b required 0", host_ack_o); end
        checks++; if (expected_seq_o !== CD'(1)) begin errors++; $display("FAIL rst_seq got %0d required 1", expected_seq_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b required 0", overflow_o); end
        checks++; if (drop_count_o !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d required 0", drop_count_o); end
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b required 0", evt_valid_o); end
    endtask

    task automatic test_single_rx();
        bit ok;
        evt_ready_i = 1'b1;
        tick();
        rx_new_message_i = 1'b1; rx_type_i = TYPE_LOGON; rx_error_type_i = 4'h0;
        exp_q.push_back({2'd0, TYPE_LOGON, 4'h0});
        tick();
        rx_new_message_i = 1'b0;
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL lat_n1_valid got %b required 0", evt_valid_o); end
        tick();
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL lat_n2_valid got %b required 1", evt_valid_o); end
        checks++; if (evt_src_o !== 2'd0) begin errors++; $display("FAIL lat_src got %0d required 0", evt_src_o); end
        checks++; if (evt_code_o !== 8'h10) begin errors++; $display("FAIL lat_code got %h required 10", evt_code_o); end
        checks++; if (expected_seq_o !== CD'(1)) begin errors++; $display("FAIL seq_before got %0d required 1", expected_seq_o); end
        tick();
        @(negedge clk);
        checks++; if (expected_seq_o !== CD'(2)) begin errors++; $display("FAIL seq_after got %0d required 2", expected_seq_o); end
        wait_empty(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        bit ok;
        evt_ready_i = 1'b0;
        tick();
        tmr_expire_i = 1'b1; tmr_id_i = 2'd1;
        exp_q.push_back({2'd1, 8'h01});
        tick();
        tmr_expire_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            rx_new_message_i = 1'b1; rx_type_i = 4'(i + 6); rx_error_type_i = 4'h0;
            if (i < 4) exp_q.push_back({2'd0, 4'(i + 6), 4'h0});
            tick();
        end
        rx_new_message_i = 1'b0;
        @(negedge clk);
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b required 1", overflow_o); end
        checks++; if (drop_count_o !== 8'd1) begin errors++; $display("FAIL ovf_drop got %0d required 1", drop_count_o); end
        checks++; if ({evt_valid_o, evt_src_o} !== 3'b101) begin errors++; $display("FAIL ovf_blocked got v=%b s=%0d required v=1 s=1", evt_valid_o, evt_src_o); end
        acc_cyc.delete();
        evt_ready_i = 1'b1;
        wait_empty(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got %0d pending required 0", exp_q.size()); end
        checks++;
        if (acc_cyc.size() != 5) begin errors++; $display("FAIL ovf_count got %0d required 5", acc_cyc.size()); end
        else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
                    errors++; $display("FAIL ovf_spacing got %0d required 2", acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_priority();
        bit ok;
        rst = 1'b1; exp_q.delete();
        repeat (2) tick();
        rst = 1'b0; evt_ready_i = 1'b1;
        tick();
        rx_new_message_i = 1'b1; rx_type_i = 4'h2; rx_error_type_i = 4'h0;
        tmr_expire_i = 1'b1; tmr_id_i = 2'd2;
        host_req_i = 1'b1; host_cmd_i = 4'd3;
        exp_q.push_back({2'd0, 8'h20});
        exp_q.push_back({2'd1, 8'h02});
        exp_q.push_back({2'd2, 8'h03});
        @(negedge clk);
        checks++; if (host_ack_o !== 1'b1) begin errors++; $display("FAIL prio_ack got %b required 1", host_ack_o); end
        tick();
        rx_new_message_i = 1'b0; tmr_expire_i = 1'b0; host_req_i = 1'b0;
        wait_empty(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prio_drain got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_fairness();
        int  base;
        bit  got_t, got_h;
        sb_en = 1'b0; evt_ready_i = 1'b1; acc_src.delete(); base = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            rx_new_message_i = 1'b1; rx_type_i = 4'h2; rx_error_type_i = 4'h0;
            tmr_expire_i = (i == 6); tmr_id_i = 2'd0;
            if (i == 6) begin host_req_i = 1'b1; host_cmd_i = 4'd1; base = acc_src.size(); end
            if (i == 7) host_req_i = 1'b0;
        end
        tick();
        rx_new_message_i = 1'b0; tmr_expire_i = 1'b0;
        repeat (30) tick();
        got_t = 1'b0; got_h = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (base + j < acc_src.size()) begin
                if (acc_src[base + j] == 2'd1) got_t = 1'b1;
                if (acc_src[base + j] == 2'd2) got_h = 1'b1;
            end
        end
        checks++; if (!got_t) begin errors++; $display("FAIL fair_timer got no timer grant in 3, required one"); end
        checks++; if (!got_h) begin errors++; $display("FAIL fair_host got no host grant in 3, required one"); end
        sb_en = 1'b1;
    endtask

    task automatic test_seq();
        bit ok;
        logic [3:0] ty [4] = '{4'h2, TYPE_GAP_FILL, TYPE_SEQ_RESET, 4'h2};
        logic [3:0] er [4] = '{4'h6, 4'h0, 4'h0, 4'h0};
        int         sq [4] = '{50, 50, 50, 51};
        evt_ready_i = 1'b1;
        tick();
        seq_load_i = 1'b1; seq_load_val_i = CD'(50);
        tick();
        seq_load_i = 1'b0;
        @(negedge clk);
        checks++; if (expected_seq_o !== CD'(50)) begin errors++; $display("FAIL seq_load got %0d required 50", expected_seq_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            rx_new_message_i = 1'b1; rx_type_i = ty[i]; rx_error_type_i = er[i];
            exp_q.push_back({2'd0, ty[i], er[i]});
            tick();
            rx_new_message_i = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            checks++;
            if (expected_seq_o !== CD'(sq[i])) begin
                errors++; $display("FAIL seq_step%0d got %0d required %0d", i, expected_seq_o, sq[i]);
            end
        end
        evt_ready_i = 1'b0;
        tick();
        rx_new_message_i = 1'b1; rx_type_i = 4'h2; rx_error_type_i = 4'h0;
        exp_q.push_back({2'd0, 8'h20});
        tick();
        rx_new_message_i = 1'b0;
        tick();
        evt_ready_i = 1'b1; seq_load_i = 1'b1; seq_load_val_i = CD'(100);
        tick();
        seq_load_i = 1'b0;
        @(negedge clk);
        checks++; if (expected_seq_o !== CD'(100)) begin errors++; $display("FAIL seq_load_wins got %0d required 100", expected_seq_o); end
        wait_empty(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL seq_drain got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        evt_ready_i = 1'b0;
        tick();
        host_req_i = 1'b1; host_cmd_i = 4'd5;
        exp_q.push_back({2'd2, 8'h05});
        tick();
        host_req_i = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({evt_valid_o, evt_src_o, evt_code_o} !== {1'b1, 2'd2, 8'h05}) begin
                errors++; $display("FAIL stall_hold got v=%b s=%0d c=%h required v=1 s=2 c=05",
                                   evt_valid_o, evt_src_o, evt_code_o);
            end
            tick();
        end
        evt_ready_i = 1'b1;
        wait_empty(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_drain got %0d pending required 0", exp_q.size()); end
    endtask

    task automatic test_timer_merge();
        bit ok;
        int n_tmr;
        evt_ready_i = 1'b0;
        tick();
        host_req_i = 1'b1; host_cmd_i = 4'd9;
        exp_q.push_back({2'd2, 8'h09});
        tick();
        host_req_i = 1'b0;
        tick();
        tmr_expire_i = 1'b1; tmr_id_i = 2'd1;
        tick();
        tmr_id_i = 2'd3;
        tick();
        tmr_expire_i = 1'b0;
        exp_q.push_back({2'd1, 8'h03});
        repeat (3) tick();
        acc_src.delete();
        evt_ready_i = 1'b1;
        wait_empty(20, ok);
        repeat (8) tick();
        checks++; if (!ok) begin errors++; $display("FAIL merge_drain got %0d pending required 0", exp_q.size()); end
        n_tmr = 0;
        foreach (acc_src[i]) if (acc_src[i] == 2'd1) n_tmr++;
        checks++; if (n_tmr != 1) begin errors++; $display("FAIL merge_count got %0d timer events required 1", n_tmr); end
    endtask

    task automatic test_host_ack();
        int acks, dbl, n_host;
        bit prev;
        sb_en = 1'b0; evt_ready_i = 1'b1; acc_src.delete();
        acks = 0; dbl = 0; prev = 1'b0;
        tick();
        host_req_i = 1'b1; host_cmd_i = 4'd7;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (host_ack_o === 1'b1) begin
                acks++;
                if (prev) dbl++;
            end
            prev = (host_ack_o === 1'b1);
            tick();
        end
        host_req_i = 1'b0;
        repeat (10) tick();
        n_host = 0;
        foreach (acc_src[i]) if (acc_src[i] == 2'd2) n_host++;
        checks++; if (acks != n_host) begin errors++; $display("FAIL ack_per_capture got %0d acks required %0d", acks, n_host); end
        checks++; if (acks < 5) begin errors++; $display("FAIL ack_repeat got %0d acks required >=5", acks); end
        checks++; if (dbl != 0) begin errors++; $display("FAIL ack_pulse got %0d back-to-back acks required 0", dbl); end
        sb_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        evt_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            rx_new_message_i = 1'b1; rx_type_i = 4'h2; rx_error_type_i = 4'h0;
        end
        tick();
        rx_new_message_i = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b1) begin errors++; $display("FAIL mid_present got %b required 1", evt_valid_o); end
        rst = 1'b1;
        exp_q.delete();
        tick();
        @(negedge clk);
        checks++; if (evt_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b required 0", evt_valid_o); end
        checks++; if (expected_seq_o !== CD'(1)) begin errors++; $display("FAIL mid_rst_seq got %0d required 1", expected_seq_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got %b required 0", overflow_o); end
        rst = 1'b0;
        acc_src.delete();
        evt_ready_i = 1'b1;
        repeat (10) tick();
        checks++; if (acc_src.size() != 0) begin errors++; $display("FAIL mid_rst_flush got %0d events required 0", acc_src.size()); end
    endtask

    initial begin
        rst = 1'b1;
        rx_new_message_i = 1'b0; rx_error_type_i = 4'h0; rx_type_i = 4'h0;
        tmr_expire_i = 1'b0; tmr_id_i = 2'd0;
        host_req_i = 1'b0; host_cmd_i = 4'd0;
        evt_ready_i = 1'b0;
        seq_load_i = 1'b0; seq_load_val_i = '0;
        test_reset();
        test_single_rx();
        test_overflow();
        test_priority();
        test_fairness();
        test_seq();
        test_stall();
        test_timer_merge();
        test_host_ack();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
